// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the processor data-memory interface.
// Accepts one word load/store per req/ready handshake, inserts WAIT_STATES
// wait cycles, then returns a one-cycle mem_ready pulse with read data or an
// error flag for misaligned or out-of-range accesses.
// Optional feature: define DMEM_BYTE_EN to add mem_be[3:0] byte-enabled stores.
module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  mem_be,
`endif
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int AW = $clog2(DEPTH);
  // Counter preload; unused when there are no wait states.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [31:0] offset;
  logic [AW-1:0] index;
  logic        acc_err;
  logic        accept;
  logic        enter_resp;
  logic        write_en;

  // Access operands: the live inputs while idle (the zero-wait path enters
  // RESP straight from IDLE, before the captured copy exists), else the capture.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = mem_we;
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

`ifdef DMEM_BYTE_EN
  logic [3:0] be_q;

  // Byte enables are captured together with the rest of the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      be_q <= 4'h0;
    end else if (accept) begin
      be_q <= mem_be;
    end
  end

  assign acc_be = (state == IDLE) ? mem_be : be_q;
`else
  assign acc_be = 4'hF;
`endif

  // Address decode: wrap-around subtraction makes addresses below the base
  // land far out of range, so a single upper-bits test covers both sides.
  // BASE_ADDR is word aligned, so offset[1:0] equals the address low bits.
  always_comb begin
    offset  = acc_addr - BASE_ADDR;
    index   = offset[AW+1:2];
    acc_err = (offset[1:0] != 2'b00) || (offset[31:AW+2] != '0);
  end

  assign accept     = (state == IDLE) && mem_req;
  assign enter_resp = (next_state == RESP) && (state != RESP);
  // Reset is folded in so a store can never land while reset is held.
  assign write_en   = enter_resp && acc_we && !acc_err && !reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_req) begin
          next_state = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from the state; the error qualifier comes from err_q.
  always_comb begin
    mem_ready = (state == RESP);
    mem_err   = (state == RESP) && err_q;
    mem_busy  = (state != IDLE);
  end

  // Request capture, wait counter, and the response registers loaded on the
  // edge entering RESP; read data then holds until the next response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      if (accept) begin
        we_q     <= mem_we;
        addr_q   <= mem_addr;
        wdata_q  <= mem_wdata;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q     <= acc_err;
        mem_rdata <= (acc_we || acc_err) ? 32'h0 : mem[index];
      end
    end
  end

  // Word array, not reset; stores commit on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[index][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed bench for dmem_responder.
// Main instance: DEPTH=64, WAIT_STATES=1, BASE_ADDR=0, checked every cycle
// against a transaction-level model. Second instance: WAIT_STATES=0,
// BASE_ADDR=0x1000, checked with literal expectations.
module tb_dmem_responder;

  localparam int          DEPTH  = 64;
  localparam int          WS     = 1;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] B_BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  logic        mem_busy;

  logic        b_req = 1'b0;
  logic        b_we = 1'b0;
  logic [31:0] b_addr = 32'h0;
  logic [31:0] b_wdata = 32'h0;
  logic [31:0] b_rdata;
  logic        b_ready;
  logic        b_err;
  logic        b_busy;

`ifdef DMEM_BYTE_EN
  logic [3:0]  mem_be = 4'hF;
  logic [3:0]  b_be = 4'hF;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit checking = 1'b0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) u_dut (
`ifdef DMEM_BYTE_EN
    .mem_be    (mem_be),
`endif
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .mem_busy  (mem_busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(B_BASE)) u_dut_b (
`ifdef DMEM_BYTE_EN
    .mem_be    (b_be),
`endif
    .clk       (clk),
    .reset     (reset),
    .mem_req   (b_req),
    .mem_we    (b_we),
    .mem_addr  (b_addr),
    .mem_wdata (b_wdata),
    .mem_rdata (b_rdata),
    .mem_ready (b_ready),
    .mem_err   (b_err),
    .mem_busy  (b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Behavioural model: memory image plus queue of expected responses.
  typedef struct {
    int          acc_cyc;
    int          rdy_cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0] model_mem [DEPTH];
  resp_t       exp_q [$];
  logic [31:0] last_rdata = 32'h0;

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  function automatic bit modelErr(logic [31:0] addr, logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return ((addr % 4) != 0) || ((off / 4) >= DEPTH);
  endfunction

  function automatic logic [3:0] effBe(logic [3:0] be);
`ifdef DMEM_BYTE_EN
    return be;
`else
    return 4'hF;
`endif
  endfunction

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    bit          er;
    bit          eb;
    bit          ee;
    logic [31:0] erd;
    if (reset) begin
      checkOutput("reset_ready", {31'h0, mem_ready}, 32'h0);
      checkOutput("reset_busy",  {31'h0, mem_busy},  32'h0);
      checkOutput("reset_err",   {31'h0, mem_err},   32'h0);
      checkOutput("reset_rdata", mem_rdata, 32'h0);
    end else if (checking) begin
      er  = (exp_q.size() > 0) && (exp_q[0].rdy_cyc == cyc);
      eb  = (exp_q.size() > 0) && (cyc > exp_q[0].acc_cyc) && (cyc <= exp_q[0].rdy_cyc);
      ee  = er && exp_q[0].err;
      erd = er ? exp_q[0].rdata : last_rdata;
      checkOutput("ready", {31'h0, mem_ready}, {31'h0, er});
      checkOutput("busy",  {31'h0, mem_busy},  {31'h0, eb});
      checkOutput("err",   {31'h0, mem_err},   {31'h0, ee});
      checkOutput("rdata", mem_rdata, erd);
      if (er) begin
        last_rdata = exp_q[0].rdata;
        void'(exp_q.pop_front());
      end
    end
  end

  // One access on the main instance. rst_after in 1..WS pulses reset that
  // many cycles after acceptance; lat returns the observed ready latency.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int rst_after, output int lat);
    resp_t       r;
    bit          err;
    int          idx;
    logic [3:0]  eb;
    @(negedge clk);
    err = modelErr(addr, BASE);
    idx = int'((addr - BASE) / 4);
    r.acc_cyc = cyc;
    r.rdy_cyc = cyc + WS + 1;
    r.err     = err;
    r.rdata   = (we || err) ? 32'h0 : model_mem[idx];
    exp_q.push_back(r);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
`ifdef DMEM_BYTE_EN
    mem_be    = be;
`endif
    lat = -1;
    for (int k = 1; k <= WS + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mem_req   = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_we    = ~we;
      end
      if (mem_ready && lat < 0) lat = k;
      if (rst_after == k && k <= WS) begin
        #2 reset = 1'b1;
        exp_q.delete();
        last_rdata = 32'h0;
        @(negedge clk);
        #2 reset = 1'b0;
        return;
      end
    end
    if (we && !err) begin
      eb = effBe(be);
      for (int b = 0; b < 4; b++) begin
        if (eb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // One access on the zero-wait instance; samples the response cycle.
  task automatic bAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic rdy, output logic err, output logic [31:0] rd);
    @(negedge clk);
    b_req   = 1'b1;
    b_we    = we;
    b_addr  = addr;
    b_wdata = wdata;
`ifdef DMEM_BYTE_EN
    b_be    = 4'hF;
`endif
    @(negedge clk);
    b_req = 1'b0;
    rdy   = b_ready;
    err   = b_err;
    rd    = b_rdata;
  endtask

  initial begin
    int          lat;
    int          sel;
    logic [31:0] addr;
    logic        rdy;
    logic        err;
    logic [31:0] rd;
    logic [31:0] rd_seq [4];
    logic        rdy_seq [4];

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    checking = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 0, lat);
    end

    // Store discarded by reset in WAIT; the old word survives.
    applyStimulus(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 0, lat);
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, lat);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, lat);
    checkOutput("p1_old_data", mem_rdata, 32'hCAFE_F00D);

    // Store then load with one wait state: ready two cycles after acceptance.
    applyStimulus(1'b1, 32'h8, 32'h1234_5678, 4'hF, 0, lat);
    checkOutput("p2_store_lat", 32'(lat), 32'd2);
    checkOutput("p2_store_rdata", mem_rdata, 32'h0);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, 0, lat);
    checkOutput("p2_load_lat", 32'(lat), 32'd2);
    checkOutput("p2_load_rdata", mem_rdata, 32'h1234_5678);
    checkOutput("p2_load_err", {31'h0, mem_err}, 32'h0);

    // Misaligned and out-of-range accesses.
    applyStimulus(1'b0, 32'h6, 32'h0, 4'hF, 0, lat);
    checkOutput("p4_misalign_err", {31'h0, mem_err}, 32'h1);
    checkOutput("p4_misalign_rdata", mem_rdata, 32'h0);
    applyStimulus(1'b0, 32'h100, 32'h0, 4'hF, 0, lat);
    checkOutput("p4_range_ready", {31'h0, mem_ready}, 32'h1);
    checkOutput("p4_range_err", {31'h0, mem_err}, 32'h1);
    applyStimulus(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, lat);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, BASE + 32'(i * 4), 32'h0, 4'hF, 0, lat);
    end

`ifdef DMEM_BYTE_EN
    // Partial and empty byte-enable stores.
    applyStimulus(1'b1, 32'h0, 32'h1122_3344, 4'hF, 0, lat);
    applyStimulus(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 0, lat);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 0, lat);
    checkOutput("p6_be_merge", mem_rdata, 32'h11BB_33DD);
    applyStimulus(1'b1, 32'h0, 32'h5555_5555, 4'b0000, 0, lat);
    checkOutput("p6_be0_lat", 32'(lat), 32'd2);
    checkOutput("p6_be0_err", {31'h0, mem_err}, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 0, lat);
    checkOutput("p6_be0_nochange", mem_rdata, 32'h11BB_33DD);
`endif

    // Randomized traffic with occasional reset in WAIT.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      else if (sel < 8) addr = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      else              addr = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 29) == 0) ? 1 : 0, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Zero-wait instance, base 0x1000.
    bAccess(1'b0, 32'h0000_0FFC, 32'h0, rdy, err, rd);
    checkOutput("p5_below_base_ready", {31'h0, rdy}, 32'h1);
    checkOutput("p5_below_base_err", {31'h0, err}, 32'h1);
    checkOutput("p5_below_base_rdata", rd, 32'h0);
    bAccess(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, rdy, err, rd);
    checkOutput("p5_store_ready", {31'h0, rdy}, 32'h1);
    checkOutput("p5_store_rdata", rd, 32'h0);
    bAccess(1'b1, 32'h0000_1004, 32'h0BAD_F00D, rdy, err, rd);
    bAccess(1'b0, 32'h0000_1000, 32'h0, rdy, err, rd);
    checkOutput("p5_load_err", {31'h0, err}, 32'h0);
    checkOutput("p5_load_rdata", rd, 32'hA5A5_A5A5);

    // Back-to-back loads with mem_req held high: responses on cycles 1 and 3.
    @(negedge clk);
    b_req  = 1'b1;
    b_we   = 1'b0;
    b_addr = 32'h0000_1000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rdy_seq[k] = b_ready;
      rd_seq[k]  = b_rdata;
      if (k == 0) b_addr = 32'h0000_1004;
      if (k == 2) b_req = 1'b0;
    end
    checkOutput("p3_ready_c1", {31'h0, rdy_seq[0]}, 32'h1);
    checkOutput("p3_rdata_c1", rd_seq[0], 32'hA5A5_A5A5);
    checkOutput("p3_ready_c2", {31'h0, rdy_seq[1]}, 32'h0);
    checkOutput("p3_hold_c2", rd_seq[1], 32'hA5A5_A5A5);
    checkOutput("p3_ready_c3", {31'h0, rdy_seq[2]}, 32'h1);
    checkOutput("p3_rdata_c3", rd_seq[2], 32'h0BAD_F00D);
    checkOutput("p3_ready_c4", {31'h0, rdy_seq[3]}, 32'h0);
    checkOutput("p3_busy_c4", {31'h0, b_busy}, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory-side) end of the processor data-memory interface.
- Accepts word-wide load/store requests from the core's load/store path using a req/ready handshake.
- Services each request from an internal word array with a parameterisable number of wait states.
- Returns read data, or an error flag for misaligned or out-of-range accesses.

Parameters:
- DEPTH, 64, number of 32-bit words stored; power of two, 4..1024.
- WAIT_STATES, 1, extra cycles inserted between acceptance and response; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  input  1  request strobe; sampled only in IDLE.
- mem_we  input  1  1 = store, 0 = load; captured with mem_req.
- mem_addr  input  32  byte address; captured with mem_req.
- mem_wdata  input  32  store data; captured with mem_req.
- mem_rdata  output  32  load data; valid while mem_ready=1, held until the next response.
- mem_ready  output  1  one-cycle response pulse.
- mem_err  output  1  error qualifier, valid with mem_ready.
- mem_busy  output  1  high in WAIT and RESP; a request is pending.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high, named reset.
- States: IDLE, WAIT, RESP.
- Reset values: state=IDLE, mem_ready=0, mem_err=0, mem_rdata=0, mem_busy=0, wait counter=0.
- Array contents are not reset.

IDLE:
- If mem_req=1, capture mem_we, mem_addr and mem_wdata.
- If WAIT_STATES=0, go to RESP; otherwise load the counter with WAIT_STATES-1 and go to WAIT.

WAIT:
- Decrement the counter each cycle.
- When the counter is 0, go to RESP.
- mem_req is ignored.

RESP:
- mem_ready=1 for exactly this cycle, then return unconditionally to IDLE.
- mem_req is ignored here; the requester re-asserts it in IDLE.

Latency and throughput:
- mem_ready rises WAIT_STATES+1 cycles after the accepting edge.
- Maximum throughput is one access per WAIT_STATES+2 cycles.

Address decode:
- offset = captured addr - BASE_ADDR, a 32-bit unsigned wrap subtraction.
- index = offset[31:2].
- Error if addr[1:0] != 0, or if index >= DEPTH (this includes addresses below BASE_ADDR via wrap).

Store:
- The array word is written on the edge entering RESP; no write on error.
- A load issued after the store's response returns the new data.

Load:
- mem_rdata is registered on the edge entering RESP: array[index], or 32'h0 on error.
- mem_rdata holds its value in IDLE and WAIT until the next RESP.

Error responses:
- mem_err = error flag in RESP, 0 otherwise.
- A store response always has mem_rdata=0.

Reset during WAIT or RESP:
- Immediate return to IDLE with outputs cleared.
- A pending store is discarded; array contents are otherwise preserved.

Simultaneous events:
- A mem_req arriving in the same cycle the FSM returns to IDLE is accepted on the next edge, because the sample is taken in IDLE.

Optional Feature:
Macro DMEM_BYTE_EN.
- Defined:
  - Adds input mem_be[3:0], captured with mem_req.
  - A store writes only the bytes whose mem_be bit is 1; bit i selects byte [8i+7:8i].
  - A store with mem_be=4'b0000 completes with mem_ready=1, mem_err=0 and no write.
  - Loads ignore mem_be and return the full word.
  - The alignment error still applies.
- Undefined:
  - No mem_be port; every store writes all 4 bytes.

Test Plan:
1. Reset asserted mid-WAIT after a store (addr 0x10, data 0xDEADBEEF), then a load of 0x10 -> old data returned (store discarded); during reset mem_ready=0, mem_rdata=0, mem_busy=0.
2. WAIT_STATES=1: store 0x0000_0008 <- 0x1234_5678, then load 0x8 -> mem_ready rises 2 cycles after each acceptance; load gives 0x1234_5678, mem_err=0.
3. WAIT_STATES=0: back-to-back loads of 0x0 and 0x4, with mem_req held high -> responses on cycles 1 and 3; mem_req ignored during RESP.
4. Load 0x0000_0006 (misaligned) and load 0x0000_0100 (index 64, DEPTH=64) -> mem_ready=1, mem_err=1, mem_rdata=0; a preceding store to 0x100 leaves words 0..63 unchanged.
5. BASE_ADDR=0x1000: load 0x0FFC -> error; store 0x1000 <- 0xA5A5A5A5, then load 0x1000 -> 0xA5A5A5A5.
6. DMEM_BYTE_EN defined: word 0x0 = 0x11223344, store 0xAABBCCDD with mem_be=4'b0101 -> read 0x11BB33DD; mem_be=0 store -> ready with no change.
